imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Loads a program into the 256-word instruction ROM/RAM from an external byte stream, then releases the core to fetch.
- Holds the single-cycle core in reset (`cpu_rst`) while the program is being loaded.
- Assembles little-endian bytes into 32-bit words and drives the memory write port.
- Once running, checks the core's fetch address for misalignment and out-of-range accesses.

Parameters:
- DEPTH, 256, number of 32-bit instruction words in memory.
- AW, 8, word-address width; must equal clog2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- boot_start  in  1  one-cycle request to begin a load.
- boot_len  in  AW+1  number of words to load; valid range 1..DEPTH; sampled with boot_start.
- s_valid  in  1  byte-stream valid.
- s_data  in  8  byte-stream data.
- s_ready  out  1  byte accepted when s_valid & s_ready.
- mem_we  out  1  instruction-memory write strobe.
- mem_waddr  out  AW  word address.
- mem_wdata  out  32  assembled word.
- pc  in  32  core fetch byte address.
- cpu_rst  out  1  active-high reset to the core and the instruction memory.
- boot_busy  out  1  high in LOAD or WRITE.
- boot_done  out  1  high in RUN.
- boot_err  out  1  high in ERR.
- fetch_fault  out  1  sticky fetch-address fault.
- word_cnt  out  AW+1  number of words written in the current load.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; cpu_rst=1.
  - All other outputs 0; byte index, word buffer, latched length and word_cnt cleared.
  - Memory contents are untouched; a partial word is discarded.
- FSM states: IDLE, LOAD, WRITE, RUN, ERR. Outputs are registered or decoded from state only; no combinational path from s_valid to s_ready.
- IDLE:
  - Outputs: cpu_rst=1, s_ready=0.
  - boot_start with 1<=boot_len<=DEPTH → LOAD; latch len, clear word_cnt and byte index.
  - boot_start with boot_len=0 or boot_len>DEPTH → ERR.
- LOAD:
  - Outputs: s_ready=1, boot_busy=1, cpu_rst=1.
  - Each handshake stores s_data into buffer byte[byte_idx] (byte 0 = bits 7:0, little-endian), then byte_idx++.
  - On the handshake with byte_idx=3: byte_idx wraps to 0 and the next state is WRITE.
  - s_valid low stalls the load indefinitely; no timeout.
- WRITE (exactly one cycle):
  - Outputs: mem_we=1, mem_waddr=word_cnt[AW-1:0], mem_wdata=buffer, s_ready=0.
  - At the clock edge: word_cnt++.
  - If word_cnt+1==len → RUN, else → LOAD.
- Throughput with continuous s_valid: 5 cycles per word (4 accept + 1 write).
- RUN:
  - Outputs: cpu_rst=0 and boot_done=1 from the cycle after the last WRITE.
  - Fault check: if pc[1:0]!=0 or (pc>>2)>=DEPTH, fetch_fault is set at the next edge (1-cycle latency) and stays set.
  - boot_start with a valid len → LOAD (reload): cpu_rst=1 in that same next cycle, fetch_fault cleared, word_cnt cleared.
  - boot_start with an invalid len → ERR.
- ERR:
  - Outputs: boot_err=1, cpu_rst=1.
  - boot_start with a valid len → LOAD; boot_err drops on entry.
- boot_start is ignored in LOAD and WRITE.
- s_data is ignored whenever s_ready=0.
- mem_waddr and mem_wdata hold their last values when mem_we=0.
- fetch_fault is evaluated only in RUN; it is held low in every other state.
- Reset asserted mid-load aborts immediately; the next load restarts at word 0.

Test Plan:
- Reset, then boot_start, boot_len=4, stream bytes 03,A3,C4,FF, 23,A4,64,00, 33,E2,62,00, E3,0A,42,FE with s_valid held high → mem_we pulses at addresses 0..3 with FFC4A303, 0064A423, 0062E233, FE420AE3; cpu_rst falls 20 cycles after the first accept; boot_done=1; word_cnt=4.
- Same load with s_valid toggled every other cycle → identical memory writes; no byte is lost or duplicated; s_ready is never high in WRITE.
- boot_len=0 and boot_len=257 → boot_err=1, cpu_rst=1, mem_we never pulses; a following boot_start with len=1 recovers and loads 1 word to address 0.
- In RUN: pc=0x3FC → no fault; pc=0x400 → fetch_fault=1 one cycle later; pc=0x002 → fault; fault stays set until a reload boot_start clears it.
- rst=0 after 6 bytes of a 2-word load → all outputs return to reset values within the same cycle; a new load with len=2 writes address 0 first.
- boot_start in RUN with len=1 → cpu_rst=1 the next cycle; one word written to address 0; RUN re-entered; boot_start pulses during LOAD have no effect.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader for the instruction memory: pulls a little-endian byte stream
// into 32-bit words, writes them to the memory and holds the core in reset
// until the whole program is in. Once the core is running it watches the fetch
// address for misaligned or out-of-range accesses.
module imem_boot_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          boot_start,
  input  logic [AW:0]   boot_len,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   pc,
  output logic          cpu_rst,
  output logic          boot_busy,
  output logic          boot_done,
  output logic          boot_err,
  output logic          fetch_fault,
  output logic [AW:0]   word_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RUN, ERR} state_t;

  localparam logic [AW:0] DEPTH_LEN = (AW + 1)'(DEPTH);
  localparam logic [29:0] DEPTH_PC  = 30'(DEPTH);

  state_t          state_reg, state_next;
  logic [1:0]      byte_idx_reg, byte_idx_next;
  logic [AW:0]     len_reg, len_next;
  logic [AW:0]     word_cnt_reg, word_cnt_next;
  logic [AW-1:0]   waddr_reg, waddr_next;
  logic [31:0]     wdata_reg, wdata_next;
  logic            fault_reg, fault_next;

  // Bytes 0..2 are buffered; byte 3 goes straight into the output word.
  logic [7:0]      buf_reg [3];

  logic            accept;
  logic            len_ok;
  logic            pc_bad;

  assign accept = (state_reg == LOAD) && s_valid;
  assign len_ok = (boot_len != '0) && (boot_len <= DEPTH_LEN);
  assign pc_bad = (pc[1:0] != 2'b00) || (pc[31:2] >= DEPTH_PC);

  // State and datapath registers; a reset drops any partial word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      byte_idx_reg <= '0;
      len_reg      <= '0;
      word_cnt_reg <= '0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
      fault_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      byte_idx_reg <= byte_idx_next;
      len_reg      <= len_next;
      word_cnt_reg <= word_cnt_next;
      waddr_reg    <= waddr_next;
      wdata_reg    <= wdata_next;
      fault_reg    <= fault_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      // Capture the byte of this lane on its handshake.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          buf_reg[gi] <= '0;
        end else if (accept && (byte_idx_reg == 2'(gi))) begin
          buf_reg[gi] <= s_data;
        end
      end
    end
  endgenerate

  // Next-state and datapath updates.
  always_comb begin
    state_next    = state_reg;
    byte_idx_next = byte_idx_reg;
    len_next      = len_reg;
    word_cnt_next = word_cnt_reg;
    waddr_next    = waddr_reg;
    wdata_next    = wdata_reg;
    fault_next    = fault_reg;

    case (state_reg)
      IDLE, RUN, ERR: begin
        if (state_reg == RUN && pc_bad) begin
          fault_next = 1'b1;
        end
        if (boot_start) begin
          if (len_ok) begin
            state_next    = LOAD;
            len_next      = boot_len;
            word_cnt_next = '0;
            byte_idx_next = '0;
          end else begin
            state_next = ERR;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          byte_idx_next = byte_idx_reg + 2'd1;
          if (byte_idx_reg == 2'd3) begin
            state_next = WRITE;
            waddr_next = word_cnt_reg[AW-1:0];
            wdata_next = {s_data, buf_reg[2], buf_reg[1], buf_reg[0]};
          end
        end
      end
      WRITE: begin
        word_cnt_next = word_cnt_reg + (AW + 1)'(1);
        if (word_cnt_reg + (AW + 1)'(1) == len_reg) begin
          state_next = RUN;
        end else begin
          state_next = LOAD;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // The fault flag only lives while the core is running.
    if (state_next != RUN) begin
      fault_next = 1'b0;
    end
  end

  assign s_ready     = (state_reg == LOAD);
  assign mem_we      = (state_reg == WRITE);
  assign boot_busy   = (state_reg == LOAD) || (state_reg == WRITE);
  assign boot_done   = (state_reg == RUN);
  assign boot_err    = (state_reg == ERR);
  assign cpu_rst     = (state_reg != RUN);
  assign mem_waddr   = waddr_reg;
  assign mem_wdata   = wdata_reg;
  assign fetch_fault = fault_reg;
  assign word_cnt    = word_cnt_reg;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: loads, stalls, errors, fetch faults,
// reloads and a mid-load reset, each checked against hand-computed values.
module tb_imem_boot_loader;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          boot_start = 1'b0;
  logic [AW:0]   boot_len = '0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = '0;
  logic [31:0]   pc = '0;
  logic          s_ready, mem_we, cpu_rst, boot_busy, boot_done, boot_err, fetch_fault;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   word_cnt;
  logic [6:0]    status;

  imem_boot_loader #(.DEPTH(256), .AW(AW)) dut (
    .clk(clk), .rst(rst), .boot_start(boot_start), .boot_len(boot_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .pc(pc), .cpu_rst(cpu_rst), .boot_busy(boot_busy), .boot_done(boot_done),
    .boot_err(boot_err), .fetch_fault(fetch_fault), .word_cnt(word_cnt)
  );

  // {cpu_rst, s_ready, mem_we, boot_busy, boot_done, boot_err, fetch_fault}
  assign status = {cpu_rst, s_ready, mem_we, boot_busy, boot_done, boot_err, fetch_fault};

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  logic [AW-1:0] wa [64];
  logic [31:0]   wd [64];
  int            wn = 0;
  int            rdy_in_write = 0;
  logic [7:0]    prog [16];
  logic [31:0]   words [4];

  // Write-port monitor
  always @(negedge clk) begin
    if (mem_we) begin
      if (wn < 64) begin
        wa[wn] = mem_waddr;
        wd[wn] = mem_wdata;
      end
      wn++;
      if (s_ready) rdy_in_write++;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [AW-1:0] a, input logic [31:0] d);
    if (idx < 64) chk(tag, {24'h0, wa[idx], wd[idx]}, {24'h0, a, d});
    else chk(tag, 64'hdead, {24'h0, a, d});
  endtask

  task automatic set_word(input int i, input logic [31:0] w);
    for (int k = 0; k < 4; k++) prog[4*i+k] = w[8*k +: 8];
  endtask

  task automatic start(input logic [AW:0] l);
    boot_start = 1'b1;
    boot_len   = l;
    @(negedge clk);
    boot_start = 1'b0;
    boot_len   = '0;
  endtask

  // Stream n bytes of prog. res = negedges from the first accepted byte
  // until cpu_rst is seen low (-1 if not reached or not waited for).
  task automatic feed(input int n, input bit tog, input bit wait_run, output int res);
    int  idx = 0;
    int  cyc = 0;
    bit  started = 0;
    bit  phase = 0;
    res = -1;
    for (int k = 0; k < 400; k++) begin
      if (wait_run && started && !cpu_rst) begin
        res = cyc;
        break;
      end
      if (!wait_run && idx == n) break;
      phase   = ~phase;
      s_valid = (idx < n) && (!tog || phase);
      s_data  = (idx < n) ? prog[idx] : 8'h5A;
      if (s_valid && s_ready) begin
        if (idx == 0) started = 1;
        idx++;
      end
      @(negedge clk);
      if (started) cyc++;
    end
    s_valid = 1'b0;
    s_data  = 8'h5A;
  endtask

  initial begin
    int res;
    int base;
    words[0] = 32'hFFC4A303;
    words[1] = 32'h0064A423;
    words[2] = 32'h0062E233;
    words[3] = 32'hFE420AE3;

    // Reset values
    repeat (2) @(negedge clk);
    chk("reset_status", status, 7'b1000000);
    chk("reset_word_cnt", word_cnt, 0);
    chk("reset_waddr", mem_waddr, 0);
    chk("reset_wdata", mem_wdata, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_status", status, 7'b1000000);

    // Four-word load, continuous stream
    for (int i = 0; i < 4; i++) set_word(i, words[i]);
    base = wn;
    start(9'd4);
    chk("load_entry", status, 7'b1101000);
    feed(16, 0, 1, res);
    chk("cpu_rst_latency", res, 20);
    chk("t1_nwrites", wn - base, 4);
    for (int i = 0; i < 4; i++) chk_wr("t1_write", base + i, AW'(i), words[i]);
    chk("t1_run_status", status, 7'b0000100);
    chk("t1_word_cnt", word_cnt, 4);

    // Fetch address checks
    pc = 32'h3FC;
    @(negedge clk);
    chk("pc_3fc_nofault", fetch_fault, 0);
    pc = 32'h400;
    chk("pc_400_not_comb", fetch_fault, 0);
    @(negedge clk);
    chk("pc_400_fault", fetch_fault, 1);
    pc = 32'h0;
    @(negedge clk);
    chk("fault_sticky", fetch_fault, 1);

    // Reload from RUN; boot_start during LOAD is ignored
    set_word(0, 32'h12345678);
    base = wn;
    start(9'd1);
    chk("reload_status", status, 7'b1101000);
    chk("reload_word_cnt", word_cnt, 0);
    boot_start = 1'b1;
    boot_len   = 9'd0;
    @(negedge clk);
    boot_start = 1'b0;
    chk("start_ignored_in_load", status, 7'b1101000);
    feed(4, 0, 1, res);
    chk("reload_latency", res, 5);
    chk("reload_nwrites", wn - base, 1);
    chk_wr("reload_write", base, 8'd0, 32'h12345678);
    chk("reload_word_cnt_done", word_cnt, 1);
    chk("reload_run_status", status, 7'b0000100);
    pc = 32'h002;
    @(negedge clk);
    chk("pc_002_fault", fetch_fault, 1);
    pc = 32'h0;

    // Four-word load with s_valid toggling
    for (int i = 0; i < 4; i++) set_word(i, words[i]);
    base = wn;
    start(9'd4);
    chk("toggle_fault_cleared", fetch_fault, 0);
    feed(16, 1, 1, res);
    chk("toggle_reached_run", res > 0, 1);
    chk("toggle_nwrites", wn - base, 4);
    for (int i = 0; i < 4; i++) chk_wr("toggle_write", base + i, AW'(i), words[i]);
    chk("s_ready_in_write", rdy_in_write, 0);
    chk("toggle_run_status", status, 7'b0000100);

    // Invalid lengths and recovery
    base = wn;
    start(9'd0);
    chk("len0_err", status, 7'b1000010);
    start(9'd257);
    chk("len257_err", status, 7'b1000010);
    repeat (3) @(negedge clk);
    chk("err_no_write", wn - base, 0);
    set_word(0, 32'hDDCCBBAA);
    start(9'd1);
    chk("err_recover_status", status, 7'b1101000);
    feed(4, 0, 1, res);
    chk("err_recover_nwrites", wn - base, 1);
    chk_wr("err_recover_write", base, 8'd0, 32'hDDCCBBAA);

    // Reset after 6 bytes of a 2-word load
    set_word(0, 32'hCAFEF00D);
    set_word(1, 32'h0BADBEEF);
    start(9'd2);
    feed(6, 0, 0, res);
    chk("midload_word_cnt", word_cnt, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_status", status, 7'b1000000);
    chk("async_reset_word_cnt", word_cnt, 0);
    chk("async_reset_wdata", mem_wdata, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    base = wn;
    start(9'd2);
    feed(8, 0, 1, res);
    chk("restart_nwrites", wn - base, 2);
    chk_wr("restart_write0", base, 8'd0, 32'hCAFEF00D);
    chk_wr("restart_write1", base + 1, 8'd1, 32'h0BADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
